// File: rtl/stage_me_mem_pkg.sv
// Shared CPU constants for the memory (ME) pipeline stage: FSM encoding and
// the default bus timeout.
package stage_me_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } me_state_t;

  localparam int unsigned ME_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/stage_me_mem_timeout_cnt.sv
// Counts REQ cycles that pass without a bus acknowledge. tc is high during the
// cycle whose closing edge would bring the count to TIMEOUT.
module me_timeout_cnt
  import stage_me_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = ME_TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset_0,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/stage_me_mem.sv
// ME pipeline stage: passes ALU results through and runs word loads/stores on
// a request/acknowledge data bus, stalling upstream while the bus is busy.
module stage_me_mem
  import stage_me_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = ME_TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_0,
  input  logic [31:0] ans_ex,
  input  logic [31:0] b_ex,
  input  logic [4:0]  rw_ex,
  input  logic        wreg_ex,
  input  logic        rmem_ex,
  input  logic        wmem_ex,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic [31:0] ans_me,
  output logic [31:0] mo_me,
  output logic [4:0]  rw_me,
  output logic        wreg_me,
  output logic        rmem_me,
  output logic        stall_me,
  output logic        align_err,
  output logic        bus_err,
  output me_state_t   fsm_state
);

  // Bus handshake: dm_req and its address/data/strobe are registered and held
  // until the cycle dm_ack is seen high in REQ (or the timeout aborts); dm_ack
  // sampled in any other state has no effect.

  me_state_t   state_q, state_d;
  logic        mem_op, aligned, go, tc, ack_ok, abort;
  logic        aborted_q;
  logic [31:0] rdata_q;

  assign mem_op  = rmem_ex | wmem_ex;
  assign aligned = (ans_ex[1:0] == 2'b00);
  assign go      = (state_q == ST_IDLE) && mem_op && aligned;
  assign ack_ok  = (state_q == ST_REQ) && dm_ack;
  assign abort   = (state_q == ST_REQ) && !dm_ack && tc;

  me_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clock   (clock),
    .reset_0 (reset_0),
    .clear   (go),
    .enable  ((state_q == ST_REQ) && !dm_ack),
    .tc      (tc)
  );

  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ans_me   = ans_ex;
    rw_me    = rw_ex;
    stall_me = 1'b0;
    wreg_me  = 1'b0;
    rmem_me  = 1'b0;
    mo_me    = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (!mem_op) begin
          wreg_me = wreg_ex;
        end else if (aligned) begin
          stall_me = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        stall_me = 1'b1;
        if (dm_ack || tc) state_d = ST_DONE;
      end
      ST_DONE: begin
        mo_me   = rdata_q;
        state_d = ST_IDLE;
        if (!aborted_q) begin
          wreg_me = wreg_ex;
          rmem_me = rmem_ex;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= 32'd0;
      dm_wdata  <= 32'd0;
      rdata_q   <= 32'd0;
      aborted_q <= 1'b0;
      bus_err   <= 1'b0;
      align_err <= 1'b0;
    end else begin
      align_err <= (state_q == ST_IDLE) && mem_op && !aligned;
      if (go) begin
        dm_req    <= 1'b1;
        dm_we     <= wmem_ex;
        dm_addr   <= ans_ex;
        dm_wdata  <= b_ex;
        rdata_q   <= 32'd0;
        aborted_q <= 1'b0;
      end else if (ack_ok) begin
        dm_req <= 1'b0;
        dm_we  <= 1'b0;
        if (rmem_ex) rdata_q <= dm_rdata;
      end else if (abort) begin
        dm_req    <= 1'b0;
        dm_we     <= 1'b0;
        rdata_q   <= 32'd0;
        aborted_q <= 1'b1;
        bus_err   <= 1'b1;
      end
    end
  end

  assign fsm_state = state_q;

endmodule

// File: doc/stage_me_mem.md
STAGE_ME_MEM -- requirements
Module: stage_me_mem

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, max REQ-state cycles without dm_ack before abort (1..255).
REQ-002 SHALL have port: clock  input  1  rising-edge clock.
REQ-003 SHALL have port: reset_0  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: ans_ex  input  32  ALU result / word address of the instruction now in ME.
REQ-005 SHALL have port: b_ex  input  32  store data.
REQ-006 SHALL have port: rw_ex  input  5  destination register.
REQ-007 SHALL have port: wreg_ex, rmem_ex, wmem_ex  input  1 each  register-write, load, and store flags.
REQ-008 SHALL have port: dm_req, dm_we  output  1 each  bus request and write strobe.
REQ-009 SHALL have port: dm_addr, dm_wdata  output  32 each  bus address and write data.
REQ-010 SHALL have port: dm_rdata  input  32  bus read data; dm_ack  input  1  bus completion.
REQ-011 SHALL have port: ans_me, mo_me  output  32 each  to ME->WB register.
REQ-012 SHALL have port: rw_me  output  5; wreg_me, rmem_me  output  1 each  to ME->WB register.
REQ-013 SHALL have port: stall_me  output  1  freeze upstream stages.
REQ-014 SHALL have port: align_err  output  1  one-cycle pulse.
REQ-015 SHALL have port: bus_err  output  1  sticky flag.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, DONE.
REQ-017 SHALL pass ans_me=ans_ex and rw_me=rw_ex combinationally in every state.
REQ-018 In IDLE with rmem_ex=wmem_ex=0, SHALL pass wreg_me=wreg_ex, rmem_me=0, stall_me=0, mo_me=0; zero added latency.
REQ-019 In IDLE with (rmem_ex|wmem_ex) and ans_ex[1:0]=0, SHALL assert stall_me, force wreg_me=rmem_me=0 (bubble) and enter REQ next edge.
REQ-020 In REQ, SHALL register dm_req=1, dm_addr=ans_ex, dm_we=wmem_ex, dm_wdata=b_ex, all stable until ack/abort; stall_me=1; bubble outputs.
REQ-021 On dm_ack=1 in REQ, SHALL capture dm_rdata (loads only), drop dm_req next edge, enter DONE.
REQ-022 In DONE, SHALL set stall_me=0, mo_me=captured data, wreg_me=wreg_ex, rmem_me=rmem_ex, and return to IDLE unconditionally next edge.
REQ-023 Minimum memory-op latency SHALL be 3 cycles (IDLE, REQ with immediate ack, DONE).
REQ-024 SHALL count REQ cycles without ack with an 8-bit counter cleared on REQ entry; when count reaches TIMEOUT with no ack, SHALL drop dm_req, set bus_err, enter DONE with mo_me=0, wreg_me=rmem_me=0.
REQ-025 dm_ack on the same edge the counter reaches TIMEOUT SHALL take priority (normal completion).
REQ-026 Memory op in IDLE with ans_ex[1:0]!=0 SHALL issue no bus cycle, pulse align_err one cycle, force wreg_me=rmem_me=0, stall_me=0, stay IDLE.
REQ-027 dm_ack outside REQ SHALL be ignored.
REQ-028 bus_err SHALL remain set until reset.

Reset
REQ-029 reset_0=0 SHALL asynchronously force IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, captured data=0, counter=0, bus_err=0, align_err=0, including mid-REQ.
REQ-030 After reset release, first rising edge SHALL evaluate inputs as IDLE.

Structure
REQ-031 State encodings (IDLE=2'd0, REQ=2'd1, DONE=2'd2) and the default TIMEOUT SHALL live in the shared CPU constants package.
REQ-032 The timeout counter SHALL be a sub-module named me_timeout_cnt (clear, enable, terminal-count output); the rest is single-module.

Verification
REQ-033 ALU op ans_ex=0x10, wreg_ex=1, no mem -> same cycle ans_me=0x10, wreg_me=1, stall_me=0, no dm_req.
REQ-034 Load addr 0x100, ack after 2 REQ cycles, rdata 0xCAFEF00D -> stall_me high 3 cycles, then DONE mo_me=0xCAFEF00D, rmem_me=1, wreg_me=1.
REQ-035 Store addr 0x204, b_ex=0x12345678, immediate ack -> one dm_req cycle with dm_we=1, dm_wdata=0x12345678; wreg_me=0 throughout.
REQ-036 Load addr 0x102 -> align_err one pulse, dm_req never asserted, wreg_me=0, stall_me=0.
REQ-037 TIMEOUT=4, load with no ack -> dm_req high 4 cycles, bus_err=1, DONE with mo_me=0, wreg_me=0; bus_err persists.
REQ-038 reset_0 low during REQ -> dm_req=0 and IDLE immediately (before next clock), bus_err=0.
